// File: rtl/router_param.sv
// router_param: 1-to-N packet router steering header/payload/parity packets into per-port FIFOs
module router_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          vld_out,
  output logic                          busy,
  output logic                          err,
  output logic                          pkt_drop
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TW    = $clog2(TIMEOUT);
  localparam int NA    = 2**ADDR_W;

  typedef enum logic [2:0] {IDLE, LOAD_DATA, LOAD_PARITY, FULL_STALL, CHECK_PARITY, DROP} state_t;

  state_t             state_q, state_d, ret_q, ret_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, wr_sel, hdr_addr;
  logic [LEN_W-1:0]   hdr_len;
  logic [DATA_W-1:0]  par_q, par_d;
  logic               mis_q, mis_d, err_q, err_d, drop_q, drop_d;
  logic               wr, tgt_full;
  logic [NUM_PORTS-1:0] full, we;
  logic [NA-1:0]      full_x;

  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_addr = data_in[ADDR_W-1:0];
  assign full_x   = NA'(full);
  assign tgt_full = full_x[addr_q];
  assign err      = err_q;
  assign pkt_drop = drop_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    par_d   = par_q;
    mis_d   = mis_q;
    err_d   = err_q;
    drop_d  = 1'b0;
    busy    = 1'b0;
    wr      = 1'b0;
    wr_sel  = addr_q;
    case (state_q)
      IDLE: begin
        wr_sel = hdr_addr;
        if (pkt_valid) begin
          addr_d = hdr_addr;
          rem_d  = hdr_len;
          par_d  = data_in;
          wr     = int'(hdr_addr) < NUM_PORTS;
          state_d = !wr ? DROP : (hdr_len == '0) ? LOAD_PARITY : LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        busy = tgt_full;
        if (tgt_full) begin
          state_d = FULL_STALL;
          ret_d   = LOAD_DATA;
        end else if (pkt_valid) begin
          wr    = 1'b1;
          par_d = par_q ^ data_in;
          rem_d = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? LOAD_PARITY : LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        busy = tgt_full;
        if (tgt_full) begin
          state_d = FULL_STALL;
          ret_d   = LOAD_PARITY;
        end else begin
          wr      = 1'b1;
          mis_d   = data_in != par_q;
          state_d = CHECK_PARITY;
        end
      end
      FULL_STALL: begin
        busy    = 1'b1;
        state_d = tgt_full ? FULL_STALL : ret_q;
      end
      CHECK_PARITY: begin
        busy    = 1'b1;
        err_d   = mis_q;
        state_d = IDLE;
      end
      DROP: begin
        // parity byte is taken regardless of pkt_valid once the payload is consumed
        if (rem_q == '0) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else if (pkt_valid) begin
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      par_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      par_q   <= par_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [AW:0]        wp_q, wp_d, rp_q, rp_d;
    logic [TW-1:0]      tc_q, tc_d;
    logic [DATA_W-1:0]  do_q, do_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic               empty, rd, flush;
    assign empty      = wp_q == rp_q;
    assign full[p]    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign vld_out[p] = ~empty;
    assign we[p]      = wr && int'(wr_sel) == p && !full[p];
    assign data_out[p*DATA_W +: DATA_W] = do_q;
    // flush keeps a same-cycle write: read pointer jumps to the pre-write write pointer
    always_comb begin
      rd    = read_enb[p] & ~empty;
      flush = ~empty & ~read_enb[p] & (int'(tc_q) == TIMEOUT - 2);
      tc_d  = (empty | read_enb[p] | flush) ? '0 : tc_q + 1'b1;
      wp_d  = we[p] ? wp_q + 1'b1 : wp_q;
      rp_d  = flush ? wp_q : rd ? rp_q + 1'b1 : rp_q;
      do_d  = rd ? mem_q[rp_q[AW-1:0]] : do_q;
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wp_q <= '0;
        rp_q <= '0;
        tc_q <= '0;
        do_q <= '0;
      end else begin
        wp_q <= wp_d;
        rp_q <= rp_d;
        tc_q <= tc_d;
        do_q <= do_d;
      end
    end
    always_ff @(posedge clock) begin
      if (we[p]) mem_q[wp_q[AW-1:0]] <= data_in;
    end
  end
endmodule

// File: tb/tb_router_param.sv
// tb_router_param: scoreboard bench for router_param; expected bytes queued at send, popped on lane reads
module tb_router_param;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [7:0]  data_in = '0;
  logic [2:0]  read_enb = '0;
  logic [23:0] data_out;
  logic [2:0]  vld_out;
  logic        busy, err, pkt_drop;

  router_param dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
    .busy(busy), .err(err), .pkt_drop(pkt_drop)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [3][$];
  logic [2:0] pend = '0;
  logic       watch = 1'b0;
  logic       busy_seen = 1'b0;
  logic [2:0] vld_seen = '0;
  int         drop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // a read issued at one edge is compared at the following negedge
  always @(negedge clock) begin
    for (int p = 0; p < 3; p++) begin
      if (pend[p]) begin
        if (exp_q[p].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL lane%0d_extra got %0h want none", p, data_out[p*8 +: 8]);
        end else begin
          chk($sformatf("lane%0d_data", p), 32'(data_out[p*8 +: 8]), 32'(exp_q[p].pop_front()));
        end
      end
    end
    pend = reset ? 3'b000 : (read_enb & vld_out);
    if (watch) begin
      busy_seen |= busy;
      vld_seen  |= vld_out;
      drop_cnt  += int'(pkt_drop);
    end
  end

  task automatic send(input logic [7:0] b, input logic v);
    int n = 0;
    data_in = b;
    pkt_valid = v;
    @(negedge clock);
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) chk("send_busy_stuck", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic send_pkt(input int a, input int len, input logic [7:0] seed, input logic [7:0] pflip);
    logic [7:0] h, b, par;
    h = {6'(len), 2'(a)};
    par = h;
    if (a < 3) exp_q[a].push_back(h);
    send(h, 1'b1);
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i * 7);
      par ^= b;
      if (a < 3) exp_q[a].push_back(b);
      send(b, 1'b1);
    end
    b = par ^ pflip;
    if (a < 3) exp_q[a].push_back(b);
    send(b, 1'b0);
  endtask

  task automatic drain(input int p);
    int n = 0;
    read_enb[p] = 1'b1;
    @(negedge clock);
    while (vld_out[p] && n < 200) begin
      n++;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    read_enb[p] = 1'b0;
    chk($sformatf("drain%0d_left", p), 32'(exp_q[p].size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, 32'(vld_out), 32'd0);
    chk({tag, "_dout"}, 32'(data_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_drop"}, 32'(pkt_drop), 32'd0);
  endtask

  task automatic stall_then_read(input int p, input string tag);
    int n = 0;
    while (!busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_busy_full"}, 32'(busy), 32'd1);
    chk({tag, "_vld"}, 32'(vld_out), 32'(1 << p));
    repeat (3) @(negedge clock);
    chk({tag, "_busy_hold"}, 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    read_enb[p] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic e0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset("rst");
    reset = 1'b0;

    // 16-byte packet to port 1 stalls on a full FIFO until reads start
    fork
      send_pkt(1, 16, 8'hA3, 8'h00);
      stall_then_read(1, "t1");
    join
    drain(1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // bad parity: err rises the cycle after CHECK_PARITY
    read_enb[1] = 1'b1;
    send_pkt(1, 16, 8'hA3, 8'h01);
    @(negedge clock);
    chk("t2_check_busy", 32'(busy), 32'd1);
    chk("t2_err_before", 32'(err), 32'd0);
    @(negedge clock);
    chk("t2_err_set", 32'(err), 32'd1);
    drain(1);

    // invalid address 3: dropped, err untouched
    watch = 1'b1;
    send_pkt(3, 5, 8'h11, 8'h00);
    chk("t5_drop_pulse", 32'(pkt_drop), 32'd1);
    @(posedge clock);
    #1;
    chk("t5_drop_end", 32'(pkt_drop), 32'd0);
    @(negedge clock);
    watch = 1'b0;
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t5_busy_seen", 32'(busy_seen), 32'd0);
    chk("t5_vld_seen", 32'(vld_seen), 32'd0);
    chk("t5_err_kept", 32'(err), 32'd1);
    @(posedge clock);
    #1;

    // a good packet clears err
    send_pkt(1, 2, 8'h3C, 8'h00);
    repeat (2) @(negedge clock);
    chk("t2_err_clear", 32'(err), 32'd0);
    drain(1);

    // 20-byte packet to port 0 stalls after 16 entries
    fork
      send_pkt(0, 20, 8'h05, 8'h00);
      stall_then_read(0, "t3");
    join
    drain(0);

    // timeout flush on port 2
    fork
      send_pkt(2, 4, 8'h77, 8'h00);
      begin
        n = 0;
        while (!vld_out[2] && n < 100) begin
          @(negedge clock);
          n++;
        end
        n = 0;
        while (vld_out[2] && n < 100) begin
          @(negedge clock);
          n++;
        end
        chk("t4_flush_cycle", 32'(n), 32'd29);
      end
    join
    exp_q[2].delete();
    @(posedge clock);
    #1;
    read_enb[2] = 1'b1;
    send_pkt(2, 4, 8'h90, 8'h00);
    drain(2);
    chk("t4_err", 32'(err), 32'd0);

    // zero-length packet: header then parity equal to header
    send_pkt(0, 0, 8'h00, 8'h00);
    read_enb[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_one_left", 32'(vld_out[0]), 32'd1);
    @(posedge clock);
    #1;
    chk("t6_empty", 32'(vld_out[0]), 32'd0);
    read_enb[0] = 1'b0;
    chk("t6_err", 32'(err), 32'd0);

    // set err, then abort a packet with reset
    send_pkt(0, 1, 8'h55, 8'h80);
    repeat (2) @(negedge clock);
    chk("t6_err_set", 32'(err), 32'd1);
    drain(0);
    send(8'h21, 1'b1);
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b1);
    e0 = vld_out[1];
    chk("t6_partial_vld", 32'(e0), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset("t6_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    read_enb[1] = 1'b1;
    send_pkt(1, 3, 8'h4D, 8'h00);
    drain(1);
    chk("t6_post_err", 32'(err), 32'd0);
    chk("t6_post_vld", 32'(vld_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
